// File: rtl/ps2_cmd_sched_if.sv
// ---------------------------------------------------------------------------
// ps2_cmd_sched_if
// Purpose : command handshake between the PS/2 command scheduler (master)
//           and the Life-game engine (slave).
// Signals :
//   cmd_valid  master->slave  FIFO head holds a command
//   cmd_code   master->slave  4-bit command code at the FIFO head
//   cmd_ready  slave->master  engine takes the head on an edge with valid&ready
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface ps2_cmd_sched_if;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready
  );
endinterface

// File: rtl/ps2_cmd_sched.sv
// ---------------------------------------------------------------------------
// ps2_cmd_sched
// Purpose : turns the PS/2 key level stream into a rate-controlled command
//           stream for the Life-game engine. Detects presses, auto-repeats
//           held navigation/step keys, queues commands in a 2-entry FIFO and
//           keeps the run/pause flag and the speed level locally.
// Ports   :
//   clk          system clock
//   rst          synchronous active-high reset
//   i_ps2_byte   current scan code from the PS/2 receiver
//   i_ps2_state  1 = key in i_ps2_byte is held
//   io_cmd       master side of the command handshake (valid/code/ready)
//   o_run        1 = free-running generations, 0 = paused
//   o_speed      generation-rate level, 0..SPEED_MAX
//   o_drop_cnt   saturating count of press events lost to a full FIFO
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_cmd_sched #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 4_000_000,
  parameter int CNT_W         = 32,
  parameter int SPEED_MAX     = 7,
  parameter int SPEED_RST     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_ps2_byte,
  input  logic              i_ps2_state,
  ps2_cmd_sched_if.master   io_cmd,
  output logic              o_run,
  output logic [2:0]        o_speed,
  output logic [7:0]        o_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_RPT = 2'd2
  } stateT;

  localparam logic [3:0] LOC_SPACE  = 4'd0;
  localparam logic [3:0] LOC_SPD_DN = 4'd1;
  localparam logic [3:0] LOC_SPD_UP = 4'd2;

  // Decoded key: {known, local, code}. Local keys reuse the code field as a
  // small opcode that never reaches the FIFO.
  function automatic logic [5:0] decodeKey(input logic [7:0] scan);
    logic [5:0] res;
    res = '0;
    case (scan)
      8'h75:   res = {2'b10, 4'd0};
      8'h72:   res = {2'b10, 4'd1};
      8'h6B:   res = {2'b10, 4'd2};
      8'h74:   res = {2'b10, 4'd3};
      8'h1D:   res = {2'b10, 4'd4};
      8'h5A:   res = {2'b10, 4'd5};
      8'h43:   res = {2'b10, 4'd6};
      8'h44:   res = {2'b10, 4'd7};
      8'h21:   res = {2'b10, 4'd8};
      8'h4D:   res = {2'b10, 4'd9};
      8'h2D:   res = {2'b10, 4'd10};
      8'h24:   res = {2'b10, 4'd11};
      8'h23:   res = {2'b10, 4'd12};
      8'h29:   res = {2'b11, LOC_SPACE};
      8'h54:   res = {2'b11, LOC_SPD_DN};
      8'h5B:   res = {2'b11, LOC_SPD_UP};
      default: res = '0;
    endcase
    return res;
  endfunction

  logic             r_sState;
  logic [7:0]       r_sByte;
  logic             r_pState;
  logic [7:0]       r_pByte;
  logic             r_blocked;
  stateT            r_state;
  stateT            w_nextState;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_nextTimer;
  logic             w_emit;
  logic             w_emitPress;
  logic             r_evValid;
  logic             r_evPress;
  logic             r_evLocal;
  logic [3:0]       r_evCode;
  logic [5:0]       w_key;
  logic             w_keyValid;
  logic             w_keyLocal;
  logic [3:0]       w_keyCode;
  logic             w_repeatable;
  logic             w_press;
  logic [3:0]       r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_pushReq;
  logic             w_pushOk;
  logic             w_push;
  logic             w_drop;
  logic             r_run;
  logic [2:0]       r_speed;
  logic [7:0]       r_dropCnt;

  // Input stage plus a one-cycle history of it. These registers only follow
  // the keyboard, so they are deliberately left out of reset: that way a key
  // still held through reset stays visible as held and cannot fake a press.
  always_ff @(posedge clk) begin
    r_sState <= i_ps2_state;
    r_sByte  <= i_ps2_byte;
    r_pState <= r_sState;
    r_pByte  <= r_sByte;
  end

  // After reset all presses are ignored until the key line is seen released,
  // so a key held across reset produces nothing until it is pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blocked <= 1'b1;
    end else if (!r_sState) begin
      r_blocked <= 1'b0;
    end
  end

  assign w_key        = decodeKey(r_sByte);
  assign w_keyValid   = w_key[5];
  assign w_keyLocal   = w_key[4];
  assign w_keyCode    = w_key[3:0];
  assign w_repeatable = w_keyValid && !w_keyLocal &&
                        ((w_keyCode <= 4'd3) || (w_keyCode == 4'd5));
  assign w_press      = r_sState && !r_blocked &&
                        (!r_pState || (r_sByte != r_pByte));

  // FSM state, hold timer and the registered event it emits. Registering the
  // event adds the cycle between a key being sampled and the FIFO push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_evValid <= 1'b0;
      r_evPress <= 1'b0;
      r_evLocal <= 1'b0;
      r_evCode  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_timer   <= w_nextTimer;
      r_evValid <= w_emit;
      r_evPress <= w_emitPress;
      r_evLocal <= w_keyLocal;
      r_evCode  <= w_keyCode;
    end
  end

  // Next-state logic. Release always wins, then a new press restarts the
  // delay; unknown codes still track the hold but never emit. Non-repeatable
  // keys park in HOLD_DLY with the timer frozen.
  always_comb begin
    w_nextState = r_state;
    w_nextTimer = r_timer;
    w_emit      = 1'b0;
    w_emitPress = 1'b0;
    if (!r_sState) begin
      w_nextState = IDLE;
      w_nextTimer = '0;
    end else if (w_press) begin
      w_nextState = HOLD_DLY;
      w_nextTimer = '0;
      w_emit      = w_keyValid;
      w_emitPress = 1'b1;
    end else begin
      case (r_state)
        HOLD_DLY: begin
          if (w_repeatable) begin
            if (r_timer == CNT_W'(REPEAT_DELAY - 1)) begin
              w_nextState = HOLD_RPT;
              w_nextTimer = '0;
              w_emit      = 1'b1;
            end else begin
              w_nextTimer = r_timer + 1'b1;
            end
          end
        end
        HOLD_RPT: begin
          if (r_timer == CNT_W'(REPEAT_PERIOD - 1)) begin
            w_nextTimer = '0;
            w_emit      = 1'b1;
          end else begin
            w_nextTimer = r_timer + 1'b1;
          end
        end
        default: begin
          w_nextState = r_state;
        end
      endcase
    end
  end

  // FIFO push policy: presses take any free slot (a slot freed by a pop on
  // the same edge counts), repeats only go into an empty FIFO so they never
  // pile up behind a stalled engine.
  assign w_pop     = (r_count != 2'd0) && io_cmd.cmd_ready;
  assign w_pushReq = r_evValid && !r_evLocal;
  assign w_pushOk  = (r_count != 2'd2) || w_pop;
  assign w_push    = w_pushReq && (r_evPress ? w_pushOk : (r_count == 2'd0));
  assign w_drop    = w_pushReq && r_evPress && !w_pushOk;

  // FIFO storage, drop counter and the locally owned run/speed state. When
  // full with a simultaneous pop, write and read pointers coincide, so the
  // new entry lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem     <= '{default: 4'd0};
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_count   <= 2'd0;
      r_dropCnt <= 8'd0;
      r_run     <= 1'b0;
      r_speed   <= 3'(SPEED_RST);
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= r_evCode;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_dropCnt != 8'hFF)) begin
        r_dropCnt <= r_dropCnt + 8'd1;
      end
      if (r_evValid && r_evLocal && r_evPress) begin
        case (r_evCode)
          LOC_SPACE:  r_run <= ~r_run;
          LOC_SPD_UP: if (r_speed != 3'(SPEED_MAX)) r_speed <= r_speed + 3'd1;
          LOC_SPD_DN: if (r_speed != 3'd0) r_speed <= r_speed - 3'd1;
          default:    r_run <= r_run;
        endcase
      end
    end
  end

  assign io_cmd.cmd_valid = (r_count != 2'd0);
  assign io_cmd.cmd_code  = r_mem[r_rdPtr];
  assign o_run            = r_run;
  assign o_speed          = r_speed;
  assign o_drop_cnt       = r_dropCnt;

endmodule
